// File: rtl/fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_queue: MIPS fetch stage - PC generation, single-outstanding imem   |
// | handshake, DEPTH-entry instruction queue, delay-slot aware redirect.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_queue #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          DELAY_SLOT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic [31:0] redirect_ds_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_is_jump
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  state_t             r_state;
  logic [31:0]        r_pc, r_req_addr, r_tgt;
  logic               r_ds_pending, r_drop;
  logic [c_PTR_W-1:0] r_rptr, r_wptr;
  logic [c_CNT_W-1:0] r_count;
  logic [31:0]        r_instr_mem [DEPTH];
  logic [31:0]        r_pc_mem    [DEPTH];

  logic               w_pop, w_resp, w_push, w_outstanding, w_head_valid;
  logic [c_PTR_W-1:0] w_rptr_pop, w_wptr_next;
  logic [c_CNT_W-1:0] w_cnt_rem, w_cnt_next;
  logic [31:0]        w_head_pc, w_pc_next, w_tgt_next;
  logic               w_ds_next, w_drop_next;

  assign w_pop         = (r_count != '0) && out_ready;
  assign w_resp        = (r_state == S_WAIT) && imem_resp_valid;
  assign w_push        = w_resp && !r_drop;
  assign w_outstanding = (r_state == S_REQ) || ((r_state == S_WAIT) && !imem_resp_valid);
  assign w_rptr_pop    = r_rptr + c_PTR_W'(w_pop);
  assign w_cnt_rem     = r_count - c_CNT_W'(w_pop);
  // Head seen by a redirect: oldest survivor of the pop, else the entry pushed this cycle.
  assign w_head_valid  = (w_cnt_rem != '0) || w_push;
  assign w_head_pc     = (w_cnt_rem != '0) ? r_pc_mem[w_rptr_pop] : r_req_addr;

  always_comb begin
    w_pc_next   = w_push ? (r_ds_pending ? r_tgt : r_pc + 32'd4) : r_pc;
    w_tgt_next  = r_tgt;
    w_ds_next   = r_ds_pending && !w_push;
    w_drop_next = w_resp ? 1'b0 : r_drop;
    w_wptr_next = r_wptr + c_PTR_W'(w_push);
    w_cnt_next  = w_cnt_rem + c_CNT_W'(w_push);
    if (redirect_valid) begin
      if (DELAY_SLOT == 0) begin
        w_wptr_next = w_rptr_pop;
        w_cnt_next  = '0;
        w_pc_next   = redirect_target;
        w_ds_next   = 1'b0;
        if (w_outstanding) w_drop_next = 1'b1;
      end else if (r_ds_pending && !w_push) begin
        w_tgt_next = redirect_target;
      end else if (w_head_valid && (w_head_pc == redirect_ds_pc)) begin
        w_wptr_next = w_rptr_pop + c_PTR_W'(1);
        w_cnt_next  = c_CNT_W'(1);
        w_pc_next   = redirect_target;
        if (w_outstanding) w_drop_next = 1'b1;
      end else if (w_pop && (r_pc_mem[r_rptr] == redirect_ds_pc)) begin
        w_wptr_next = w_rptr_pop;
        w_cnt_next  = '0;
        w_pc_next   = redirect_target;
        if (w_outstanding) w_drop_next = 1'b1;
      end else if (w_outstanding && !r_drop && (r_req_addr == redirect_ds_pc)) begin
        // In-flight fetch is the slot: keep it and chain the target behind its push.
        w_wptr_next = w_rptr_pop;
        w_cnt_next  = '0;
        w_ds_next   = 1'b1;
        w_tgt_next  = redirect_target;
      end else begin
        w_wptr_next = w_rptr_pop;
        w_cnt_next  = '0;
        w_pc_next   = redirect_ds_pc;
        w_ds_next   = 1'b1;
        w_tgt_next  = redirect_target;
        if (w_outstanding) w_drop_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_tgt        <= '0;
      r_ds_pending <= 1'b0;
      r_drop       <= 1'b0;
      r_rptr       <= '0;
      r_wptr       <= '0;
      r_count      <= '0;
    end else begin
      r_pc         <= w_pc_next;
      r_tgt        <= w_tgt_next;
      r_ds_pending <= w_ds_next;
      r_drop       <= w_drop_next;
      r_rptr       <= w_rptr_pop;
      r_wptr       <= w_wptr_next;
      r_count      <= w_cnt_next;
      case (r_state)
        S_IDLE: begin
          if (r_count < c_DEPTH) begin
            r_state    <= S_REQ;
            r_req_addr <= w_pc_next;
          end
        end
        S_REQ: begin
          if (imem_req_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (w_cnt_next < c_DEPTH) begin
              r_state    <= S_REQ;
              r_req_addr <= w_pc_next;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wptr] <= imem_resp_data;
      r_pc_mem[r_wptr]    <= r_req_addr;
    end
  end

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_req_addr;
  assign out_valid      = (r_count != '0);
  assign out_instr      = r_instr_mem[r_rptr];
  assign out_pc         = r_pc_mem[r_rptr];
  assign out_is_jump    = (out_instr[31:26] == 6'b000010) || (out_instr[31:26] == 6'b000011);

endmodule
`default_nettype wire
